pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX.
- Squashes wrong-path instructions when a branch resolves taken in MEM.
- Freezes the whole pipeline while data memory is not ready, and halts on a memory timeout.
- Drives the enable/flush inputs of the PC and the four inter-stage latches.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 19 +
 rtl/pipeline_hazard_ctrl_if.sv | 18 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 14 +
 rtl/pipeline_hazard_ctrl.sv | 79 +++++++
 tb/tb_pipeline_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;
  localparam ctrl_t CTRL_FROZEN   = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTRL_RUN      = ctrl_t'(8'b1111_1000);
  localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b1111_1111);
  localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(8'b0011_1010);
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side signals of the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_mem_read, mem_branch_taken, mem_access, dmem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken, mem_access, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
    output mem_timeout, stall_cnt, flush_cnt
  );
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken, mem_access, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
    input  mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between ID and EX
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  output logic       load_use_o
);
  assign load_use_o = ex_mem_read_i && ex_rt_i != REG_ZERO &&
                      (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller with memory-wait FSM and perf counters
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  state_e state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic timeout_q, timeout_d, load_use, active;
  ctrl_t ctrl, run_ctrl;
  hazard_detect u_hazard_detect (
    .id_rs_i      (bus.id_rs),
    .id_rt_i      (bus.id_rt),
    .id_uses_rt_i (bus.id_uses_rt),
    .ex_mem_read_i(bus.ex_mem_read),
    .ex_rt_i      (bus.ex_rt),
    .load_use_o   (load_use)
  );
  // a taken branch squashes the ID instruction, so it outranks load-use
  assign run_ctrl = bus.mem_branch_taken ? CTRL_BRANCH : load_use ? CTRL_LOAD_USE : CTRL_RUN;
  always_comb begin
    ctrl      = CTRL_FROZEN;
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN:
        if (bus.mem_access && !bus.dmem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end else ctrl = run_ctrl;
      MEM_WAIT:
        if (bus.dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
          ctrl    = run_ctrl;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_d   = HALT;
            timeout_d = 1'b1;
          end
        end
      default: ;
    endcase
    if (!rst_n) ctrl = CTRL_FROZEN;
  end
  assign active  = state_q != HALT;
  assign stall_d = (active && !ctrl.pc_en && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  assign flush_d = (active && ctrl.exmem_flush && flush_q != '1) ? flush_q + 1'b1 : flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end
  assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
          bus.ifid_flush, bus.idex_flush, bus.exmem_flush} = ctrl;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scenario tasks plus randomized run against a rule-level model
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] ctrl_vec;
  assign ctrl_vec = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                     bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
  // model: 0 running, 1 waiting on memory, 2 halted
  int m_mode, m_waited, m_stall, m_flush;
  bit m_to;
  function automatic logic [7:0] exp_ctrl();
    bit hazard, advancing;
    hazard = bus.ex_mem_read && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
    advancing = (m_mode == 0 && !(bus.mem_access && !bus.dmem_ready)) || (m_mode == 1 && bus.dmem_ready);
    if (!rst_n || !advancing) return 8'h00;
    if (bus.mem_branch_taken) return 8'hFF;
    if (hazard) return 8'h3A;
    return 8'hF8;
  endfunction
  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask
  task automatic step();
    logic [7:0] e;
    e = exp_ctrl();
    if (m_mode != 2) begin
      if (!e[7] && m_stall < MAXC) m_stall++;
      if (e[0] && m_flush < MAXC) m_flush++;
    end
    if (m_mode == 0 && bus.mem_access && !bus.dmem_ready) begin
      m_mode = 1; m_waited = 1;
    end else if (m_mode == 1) begin
      if (bus.dmem_ready) m_mode = 0;
      else begin
        m_waited++;
        if (m_waited == TO) begin m_mode = 2; m_to = 1; end
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic clear_inputs();
    bus.id_rs = 0; bus.id_rt = 0; bus.ex_rt = 0; bus.id_uses_rt = 0; bus.ex_mem_read = 0;
    bus.mem_branch_taken = 0; bus.mem_access = 0; bus.dmem_ready = 1;
  endtask
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    model_reset();
    bus.id_rs = 5; bus.ex_rt = 5; bus.ex_mem_read = 1; bus.mem_branch_taken = 1;
    bus.mem_access = 0; bus.dmem_ready = 1; bus.id_rt = 0; bus.id_uses_rt = 0;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got %h want 00", ctrl_vec); end
    n_checks++;
    if (bus.stall_cnt !== 0 || bus.flush_cnt !== 0 || bus.mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got s=%0d f=%0d t=%b want 0 0 0", bus.stall_cnt, bus.flush_cnt, bus.mem_timeout);
    end
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1;
  endtask
  task automatic test_load_use();
    do_reset();
    bus.ex_mem_read = 1; bus.ex_rt = 5; bus.id_rs = 5;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'h3A || ctrl_vec !== exp_ctrl()) begin n_fail++; $display("FAIL load_use_ctrl got %h want 3a", ctrl_vec); end
    step();
    n_checks++;
    if (bus.stall_cnt !== 1) begin n_fail++; $display("FAIL load_use_stall got %0d want 1", bus.stall_cnt); end
    bus.ex_mem_read = 0;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'hF8) begin n_fail++; $display("FAIL load_use_after got %h want f8", ctrl_vec); end
    step();
  endtask
  task automatic test_zero_reg();
    do_reset();
    bus.ex_mem_read = 1; bus.ex_rt = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 1;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'hF8) begin n_fail++; $display("FAIL zero_reg_ctrl got %h want f8", ctrl_vec); end
    step();
    bus.ex_rt = 7; bus.id_rt = 7; bus.id_rs = 3; bus.id_uses_rt = 0;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'hF8) begin n_fail++; $display("FAIL rt_unused_ctrl got %h want f8", ctrl_vec); end
    step();
    n_checks++;
    if (bus.stall_cnt !== 0) begin n_fail++; $display("FAIL zero_reg_stall got %0d want 0", bus.stall_cnt); end
    bus.id_uses_rt = 1;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'h3A) begin n_fail++; $display("FAIL rt_used_ctrl got %h want 3a", ctrl_vec); end
    step();
  endtask
  task automatic test_branch_load_use();
    do_reset();
    bus.ex_mem_read = 1; bus.ex_rt = 9; bus.id_rs = 9; bus.mem_branch_taken = 1;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'hFF) begin n_fail++; $display("FAIL branch_ctrl got %h want ff", ctrl_vec); end
    step();
    n_checks++;
    if (bus.flush_cnt !== 1 || bus.stall_cnt !== 0) begin
      n_fail++; $display("FAIL branch_cnt got f=%0d s=%0d want 1 0", bus.flush_cnt, bus.stall_cnt);
    end
  endtask
  task automatic test_mem_wait();
    do_reset();
    bus.mem_access = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctrl_vec !== 8'h00) begin n_fail++; $display("FAIL mem_wait_frozen[%0d] got %h want 00", i, ctrl_vec); end
      step();
    end
    bus.dmem_ready = 1; bus.mem_branch_taken = 1;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'hFF) begin n_fail++; $display("FAIL mem_wait_ready got %h want ff", ctrl_vec); end
    step();
    n_checks++;
    if (bus.stall_cnt !== 3 || bus.flush_cnt !== 1) begin
      n_fail++; $display("FAIL mem_wait_cnt got s=%0d f=%0d want 3 1", bus.stall_cnt, bus.flush_cnt);
    end
    bus.mem_branch_taken = 0; bus.mem_access = 0;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'hF8) begin n_fail++; $display("FAIL mem_wait_run got %h want f8", ctrl_vec); end
    step();
  endtask
  task automatic test_timeout();
    do_reset();
    bus.mem_access = 1; bus.dmem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early[%0d] got 1 want 0", i); end
      step();
    end
    n_checks++;
    if (bus.mem_timeout !== 1'b1 || bus.stall_cnt !== TO) begin
      n_fail++; $display("FAIL timeout_set got t=%b s=%0d want 1 %0d", bus.mem_timeout, bus.stall_cnt, TO);
    end
    bus.dmem_ready = 1; bus.mem_branch_taken = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctrl_vec !== 8'h00) begin n_fail++; $display("FAIL halt_frozen[%0d] got %h want 00", i, ctrl_vec); end
      step();
    end
    n_checks++;
    if (bus.stall_cnt !== TO || bus.flush_cnt !== 0) begin
      n_fail++; $display("FAIL halt_cnt got s=%0d f=%0d want %0d 0", bus.stall_cnt, bus.flush_cnt, TO);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (bus.mem_timeout !== 1'b0 || bus.stall_cnt !== 0 || ctrl_vec !== 8'hF8) begin
      n_fail++; $display("FAIL halt_cleared got t=%b s=%0d c=%h want 0 0 f8", bus.mem_timeout, bus.stall_cnt, ctrl_vec);
    end
    step();
  endtask
  task automatic test_async_reset();
    do_reset();
    bus.mem_access = 1; bus.dmem_ready = 0;
    step();
    step();
    #1 rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (ctrl_vec !== 8'h00 || bus.stall_cnt !== 0) begin
      n_fail++; $display("FAIL async_reset got c=%h s=%0d want 00 0", ctrl_vec, bus.stall_cnt);
    end
    bus.mem_access = 0;
    #1 rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (ctrl_vec !== 8'hF8) begin n_fail++; $display("FAIL async_release got %h want f8", ctrl_vec); end
    step();
    n_checks++;
    if (bus.stall_cnt !== 0) begin n_fail++; $display("FAIL async_release_cnt got %0d want 0", bus.stall_cnt); end
  endtask
  task automatic test_saturation();
    do_reset();
    bus.ex_mem_read = 1; bus.ex_rt = 4; bus.id_rs = 4;
    for (int i = 0; i < MAXC + 3; i++) step();
    n_checks++;
    if (bus.stall_cnt !== MAXC) begin n_fail++; $display("FAIL stall_sat got %0d want %0d", bus.stall_cnt, MAXC); end
    bus.mem_branch_taken = 1;
    for (int i = 0; i < MAXC + 3; i++) step();
    n_checks++;
    if (bus.flush_cnt !== MAXC || bus.stall_cnt !== MAXC) begin
      n_fail++; $display("FAIL flush_sat got f=%0d s=%0d want %0d", bus.flush_cnt, bus.stall_cnt, MAXC);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_rt = 5'($urandom_range(0, 3));
      bus.id_uses_rt = 1'($urandom_range(0, 1));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.mem_branch_taken = $urandom_range(0, 4) == 0;
      bus.mem_access = $urandom_range(0, 2) == 0;
      bus.dmem_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      n_checks++;
      if (ctrl_vec !== exp_ctrl()) begin n_fail++; $display("FAIL rand_ctrl[%0d] got %h want %h", i, ctrl_vec, exp_ctrl()); end
      n_checks++;
      if (bus.stall_cnt !== CW'(m_stall) || bus.flush_cnt !== CW'(m_flush) || bus.mem_timeout !== m_to) begin
        n_fail++;
        $display("FAIL rand_state[%0d] got s=%0d f=%0d t=%b want %0d %0d %b",
                 i, bus.stall_cnt, bus.flush_cnt, bus.mem_timeout, m_stall, m_flush, m_to);
      end
      step();
    end
  endtask
  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
